// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with two write ports, two combinational
// read ports, optional same-cycle write-to-read bypass, optional hardwired-zero R0
// and a per-register pending-load scoreboard.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst_n          synchronous active-low reset; clears data and busy bits
//   wrA_*          write port A (ALU writeback)
//   wrB_*          write port B (load writeback); wins over A on the same address
//   busy_set_*     mark a register as awaiting a load
//   rd_addrA/B     combinational read addresses
//   datA/B_out     read data
//   busyA/B        pending-load flag of the register being read
module reg_file_mp #(
  parameter int unsigned DW      = 8,
  parameter int unsigned PW      = 4,
  parameter bit          ZERO_R0 = 1'b0,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrA_en,
  input  logic [PW-1:0] wrA_addr,
  input  logic [DW-1:0] wrA_dat,
  input  logic          wrB_en,
  input  logic [PW-1:0] wrB_addr,
  input  logic [DW-1:0] wrB_dat,
  input  logic          busy_set_en,
  input  logic [PW-1:0] busy_set_addr,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busyA,
  output logic          busyB
);

  localparam int unsigned Depth = 1 << PW;

  logic [DW-1:0]    r_mem [Depth];
  logic [Depth-1:0] r_busy;
  logic [Depth-1:0] w_busy_d;

  logic             w_wrA_ok;
  logic             w_wrB_ok;
  logic             w_set_ok;

  logic [PW-1:0]    w_rd_addr [2];
  logic [DW-1:0]    w_rd_dat  [2];
  logic [1:0]       w_rd_busy;

  // With a hardwired R0, anything aimed at address 0 is simply dropped.
  assign w_wrA_ok = wrA_en      && !(ZERO_R0 && (wrA_addr == '0));
  assign w_wrB_ok = wrB_en      && !(ZERO_R0 && (wrB_addr == '0));
  assign w_set_ok = busy_set_en && !(ZERO_R0 && (busy_set_addr == '0));

  // Busy next state: writes clear, a set is applied last so it wins, since it
  // describes a newer outstanding load than the one just returning.
  always_comb begin
    w_busy_d = r_busy;
    if (w_wrA_ok) w_busy_d[wrA_addr] = 1'b0;
    if (w_wrB_ok) w_busy_d[wrB_addr] = 1'b0;
    if (w_set_ok) w_busy_d[busy_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wrA_ok) r_mem[wrA_addr] <= wrA_dat;
      // Port B is written after A so it takes the register on an address clash.
      if (w_wrB_ok) r_mem[wrB_addr] <= wrB_dat;
      r_busy <= w_busy_d;
    end
  end

  assign w_rd_addr[0] = rd_addrA;
  assign w_rd_addr[1] = rd_addrB;

  // Read path: stored value, then bypass A, then bypass B (B has priority),
  // then the R0 override. A bypassed register is never reported busy because
  // its fresh data is already on the read port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_dat[p]  = r_mem[w_rd_addr[p]];
      w_rd_busy[p] = r_busy[w_rd_addr[p]];
      if (BYPASS && w_wrA_ok && (wrA_addr == w_rd_addr[p])) begin
        w_rd_dat[p]  = wrA_dat;
        w_rd_busy[p] = 1'b0;
      end
      if (BYPASS && w_wrB_ok && (wrB_addr == w_rd_addr[p])) begin
        w_rd_dat[p]  = wrB_dat;
        w_rd_busy[p] = 1'b0;
      end
      if (ZERO_R0 && (w_rd_addr[p] == '0)) begin
        w_rd_dat[p]  = '0;
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  assign datA_out = w_rd_dat[0];
  assign datB_out = w_rd_dat[1];
  assign busyA    = w_rd_busy[0];
  assign busyB    = w_rd_busy[1];

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, successor to the 8-bit 16-entry single-write file in the datapath.
- Configurable data width and depth.
- Two write ports: ALU writeback on A, load writeback on B.
- Two combinational read ports with optional write-to-read bypass.
- Optional hardwired-zero R0.
- Per-register pending-load scoreboard so the controller can stall on read-after-load hazards.

Parameters:
DW, 8, data width in bits
PW, 4, address pointer width; depth = 2**PW registers
ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes, never marked busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
wrA_en  input  1  write enable, port A (ALU writeback)
wrA_addr  input  PW  write address, port A
wrA_dat  input  DW  write data, port A
wrB_en  input  1  write enable, port B (load writeback)
wrB_addr  input  PW  write address, port B
wrB_dat  input  DW  write data, port B
busy_set_en  input  1  mark a register as awaiting a load
busy_set_addr  input  PW  register to mark busy
rd_addrA  input  PW  read address A
rd_addrB  input  PW  read address B
datA_out  output  DW  read data A (combinational)
datB_out  output  DW  read data B (combinational)
busyA  output  1  register at rd_addrA is pending (combinational)
busyB  output  1  register at rd_addrB is pending (combinational)

Behaviour:
Reset and storage:
- One clock, clk. Reset is synchronous and active-low on rst_n: on a rising edge with rst_n=0, every register is cleared to 0 and every busy bit is cleared.
- Reset overrides all writes and busy sets in the same cycle.
- After reset, datA_out=datB_out=0 and busyA=busyB=0 for any address.
- Storage is 2**PW x DW flops. There are no memory macros.

Reads and bypass:
- Reads are combinational, with zero-cycle latency from address to data.
- Writes are registered. With BYPASS=0, written data is visible on the reads in the cycle after the edge.
- With BYPASS=1, a read whose address matches an enabled write in the same cycle returns that write's data. If both write ports match, port B's data is returned.

Writes and scoreboard:
- Both write ports to the same address in one cycle: port B wins and port A's data is discarded.
- Each register has one busy bit.
- On a clock edge, busy_set_en sets bit[busy_set_addr].
- An enabled write on either port clears bit[wr_addr].
- Set and clear to the same address in one cycle: set wins, because the set is the newer outstanding load.
- busyA/busyB = busy bit at the read address, forced to 0 when BYPASS=1 and that address is being written this cycle (data is available via bypass).

R0 handling:
- With ZERO_R0=1, address 0 reads 0 regardless of bypass.
- Writes and busy sets to address 0 are ignored.
- busy for address 0 is always 0.

Other rules:
- Mid-operation reset: pending busy bits are dropped. The controller is required to flush outstanding loads alongside reset.
- No wrap or overflow behaviour. Addresses are full-range, and every pointer value maps to a register.

Test Plan:
1. Reset: preload R3=0x5A, then hold rst_n=0 for one edge -> datA_out(rd_addrA=3)=0x00, busyA=0; repeat with wrA_en=1, wrA_addr=3, wrA_dat=0xFF during reset -> R3 stays 0x00.
2. Dual write conflict: wrA (R5, 0x11) and wrB (R5, 0x22) in the same cycle -> after the edge, R5=0x22. With BYPASS=1, datA_out=0x22 in the write cycle itself.
3. Bypass vs no bypass: write R7=0xC3 while reading R7 -> BYPASS=1: datA_out=0xC3 in the same cycle; BYPASS=0: old value in that cycle, 0xC3 in the next cycle.
4. Scoreboard:
   - busy_set R9 -> next cycle busyB(rd_addrB=9)=1.
   - Two idle cycles -> busyB stays 1.
   - wrB R9=0x40 -> busyB=0 during the write cycle (BYPASS=1) and after it.
   - Simultaneous busy_set R9 with wrA R9 -> busy bit remains 1.
5. ZERO_R0=1: wrA R0=0xAA plus busy_set R0 -> datA_out(0)=0x00 in the same and next cycle, busyA=0.
6. Parameter sweep DW=16, PW=5: write R31=0xBEEF, read on both ports -> 0xBEEF on both. Reset mid-pending (busy_set R31, then rst_n=0) -> busy cleared and R31=0x0000.
